stack_sequencer: RTL

Memory-stage controller that turns one stack-type instruction (PUSH, POP, CALL, RET, INT, RTI) into a sequence of single-word stack memory beats. For every beat it drives the stack pointer's `enable`/`pushOrPop` controls, forms the data-memory address from the current SP, and moves 16-bit words to or from data memory. It stalls the pipeline until the sequence completes, then delivers the popped register value, the return PC or the restored flags. It sits between the memory-stage pipeline register and the stack pointer / data memory pair.

---
 rtl/stack_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// Memory-stage stack controller: expands PUSH/POP/CALL/RET/INT/RTI into single-word
// stack beats against an external stack pointer and synchronous data memory.
module stack_sequencer #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] SP_RESET = 32'd2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [31:0]       pc_save,
  input  logic [3:0]        flags_in,
  input  logic [31:0]       sp_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sp_en,
  output logic              sp_pop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] pop_data,
  output logic [31:0]       pc_out,
  output logic              pc_load,
  output logic [3:0]        flags_out,
  output logic              flags_load,
  output logic              stack_err
);

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic is_push_op(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic is_pop_op(input logic [2:0] op);
    return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

  function automatic logic [1:0] beat_count(input logic [2:0] op);
    case (op)
      OP_CALL, OP_RET: return 2'd2;
      OP_INT, OP_RTI:  return 2'd3;
      default:         return 2'd1;
    endcase
  endfunction

  state_t            state;
  logic [2:0]        op_reg;
  logic [DATA_W-1:0] data_reg;
  logic [31:0]       pc_reg;
  logic [3:0]        flags_reg;
  logic [1:0]        beat_reg;
  logic              err_reg;
  logic              stall_reg;

  logic              accept;
  logic              write_beat;
  logic              read_beat;
  logic              last_beat;
  logic              beat_err;
  logic              capture_en;
  logic [1:0]        capture_idx;
  logic [ADDR_W-1:0] sp_low;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_word;

  // rst gates accept so every output reads 0 while reset is held.
  assign accept      = rst && (state == S_IDLE) && op_valid &&
                       (is_push_op(op_code) || is_pop_op(op_code));
  assign write_beat  = (state == S_WRITE);
  assign read_beat   = (state == S_READ);
  assign last_beat   = (beat_reg == beat_count(op_reg) - 2'd1);
  assign sp_low      = sp_in[ADDR_W-1:0];
  assign rd_addr     = sp_low + ADDR_W'(1);
  assign beat_err    = (write_beat && (sp_low == '0)) ||
                       (read_beat && (sp_in >= SP_RESET));

  // Read data trails its beat by one cycle; beat_reg already points past it.
  assign capture_en  = (read_beat && (beat_reg != 2'd0)) || (state == S_CAPTURE);
  assign capture_idx = beat_reg - 2'd1;

  always_comb begin
    wr_word = '0;
    case (op_reg)
      OP_PUSH: wr_word = data_reg;
      OP_CALL: wr_word = (beat_reg == 2'd0) ? DATA_W'(pc_reg[31:16]) : DATA_W'(pc_reg[15:0]);
      OP_INT: begin
        case (beat_reg)
          2'd0:    wr_word = DATA_W'(flags_reg);
          2'd1:    wr_word = DATA_W'(pc_reg[31:16]);
          default: wr_word = DATA_W'(pc_reg[15:0]);
        endcase
      end
      default: wr_word = '0;
    endcase
  end

  // Beat controls track the live sp_in, so they must stay combinational.
  assign sp_en     = write_beat || read_beat;
  assign sp_pop    = read_beat;
  assign mem_we    = write_beat;
  assign mem_re    = read_beat;
  assign mem_addr  = write_beat ? sp_low : (read_beat ? rd_addr : '0);
  assign mem_wdata = write_beat ? wr_word : '0;
  assign stall     = stall_reg || accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_reg     <= '0;
      data_reg   <= '0;
      pc_reg     <= '0;
      flags_reg  <= '0;
      beat_reg   <= '0;
      err_reg    <= 1'b0;
      stall_reg  <= 1'b0;
      done       <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      stack_err  <= 1'b0;
      pop_data   <= '0;
      pc_out     <= '0;
      flags_out  <= '0;
    end else begin
      done       <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      stack_err  <= 1'b0;

      if (capture_en) begin
        case (op_reg)
          OP_POP: pop_data <= mem_rdata;
          OP_RET, OP_RTI: begin
            case (capture_idx)
              2'd0:    pc_out[15:0]  <= mem_rdata[15:0];
              2'd1:    pc_out[31:16] <= mem_rdata[15:0];
              default: flags_out     <= mem_rdata[3:0];
            endcase
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= op_code;
            data_reg  <= reg_data;
            pc_reg    <= pc_save;
            flags_reg <= flags_in;
            beat_reg  <= 2'd0;
            err_reg   <= 1'b0;
            stall_reg <= 1'b1;
            state     <= is_push_op(op_code) ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          err_reg  <= err_reg || beat_err;
          beat_reg <= beat_reg + 2'd1;
          if (last_beat) begin
            state     <= S_DONE;
            stall_reg <= 1'b0;
            done      <= 1'b1;
            stack_err <= err_reg || beat_err;
          end
        end
        S_READ: begin
          err_reg  <= err_reg || beat_err;
          beat_reg <= beat_reg + 2'd1;
          if (last_beat) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          state      <= S_DONE;
          stall_reg  <= 1'b0;
          done       <= 1'b1;
          pc_load    <= (op_reg == OP_RET) || (op_reg == OP_RTI);
          flags_load <= (op_reg == OP_RTI);
          stack_err  <= err_reg;
        end
        S_DONE: begin
          // The finished instruction is still on op_valid here; it must not re-issue.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
